// File: rtl/rr_readout_arbiter_pkg.sv
// ============================================================================
// rr_readout_arbiter_pkg : shared FSM encoding and width helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package rr_readout_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // A single channel still needs a one-bit index field
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_readout_arbiter_if.sv
// ============================================================================
// rr_readout_arbiter_if : source-side and SRAM-side signals of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rr_readout_arbiter_if
  import rr_readout_arbiter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DSIZE = 32,
  parameter int IDW   = idx_width(WIDTH)
);

  logic [WIDTH-1:0]       WRITE_REQ;
  logic [WIDTH-1:0]       HOLD_REQ;
  logic [WIDTH*DSIZE-1:0] DATA_IN;
  logic [WIDTH-1:0]       READ_GRANT;
  logic                   READY_IN;
  logic                   WRITE_OUT;
  logic [DSIZE-1:0]       DATA_OUT;
  logic [IDW-1:0]         GRANT_ID;
  logic                   BUSY;

  modport master (
    output WRITE_REQ, HOLD_REQ, DATA_IN, READY_IN,
    input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
  );

  modport slave (
    input  WRITE_REQ, HOLD_REQ, DATA_IN, READY_IN,
    output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY
  );

endinterface

`default_nettype wire

// File: rtl/rr_readout_arbiter_pick.sv
// ============================================================================
// rr_readout_arbiter_pick : rotate-priority encoder, first requester after PTR
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_readout_arbiter_pick #(
  parameter int WIDTH = 6,
  parameter int IDW   = 3
) (
  input  wire logic [WIDTH-1:0] i_req,
  input  wire logic [IDW-1:0]   i_ptr,
  output logic                  o_valid,
  output logic [IDW-1:0]        o_idx
);

  // Walk from the far end back toward ptr+1 so the nearest hit wins
  always_comb begin
    int             v_c;
    logic [IDW-1:0] v_ci;
    v_c     = 0;
    v_ci    = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      v_c  = (int'(i_ptr) + k) % WIDTH;
      v_ci = IDW'(v_c);
      if (i_req[v_ci]) begin
        o_valid = 1'b1;
        o_idx   = v_ci;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_readout_arbiter.sv
// ============================================================================
// rr_readout_arbiter : round-robin merge of FWFT sources into one registered
//                      word stream, bounded bursts with hold-to-retain grant
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_readout_arbiter
  import rr_readout_arbiter_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 16
) (
  input  wire logic            BUS_CLK,
  input  wire logic            BUS_RST_N,
  rr_readout_arbiter_if.slave  bus
);

  localparam int IDW = idx_width(WIDTH);
  localparam int CW  = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  c_burst_max  = CW'(MAX_BURST);
  localparam logic [CW-1:0]  c_burst_last = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] c_ptr_rst    = IDW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_grant_id, w_grant_id_nxt;
  logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]    r_burst_cnt, w_burst_cnt_nxt;
  logic             r_write_out;
  logic [DSIZE-1:0] r_data_out;

  logic             w_accept, w_pop, w_req_g, w_hold_g;
  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick_idx;
  logic [DSIZE-1:0] w_slice;
  logic [WIDTH-1:0] w_read_grant;

  rr_readout_arbiter_pick #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_pick (
    .i_req   (bus.WRITE_REQ),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_accept = ~r_write_out | bus.READY_IN;
  assign w_req_g  = bus.WRITE_REQ[r_grant_id];
  assign w_hold_g = bus.HOLD_REQ[r_grant_id];
  assign w_pop    = BUS_RST_N & (r_state == ST_GRANT) & w_req_g & w_accept;

  always_comb begin
    w_slice      = '0;
    w_read_grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_slice         = bus.DATA_IN[i*DSIZE +: DSIZE];
        w_read_grant[i] = w_pop;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_state     <= ST_IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= c_ptr_rst;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt     = ST_GRANT;
          w_grant_id_nxt  = w_pick_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_pop && (r_burst_cnt != c_burst_max))
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        // A pop coinciding with release still lands in the output register
        if (!w_hold_g && ((w_pop && (r_burst_cnt >= c_burst_last)) || !w_req_g)) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = r_grant_id;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      r_write_out <= 1'b0;
      r_data_out  <= '0;
    end else if (w_pop) begin
      r_write_out <= 1'b1;
      r_data_out  <= w_slice;
    end else if (bus.READY_IN) begin
      r_write_out <= 1'b0;
    end
  end

  assign bus.READ_GRANT = w_read_grant;
  assign bus.WRITE_OUT  = r_write_out;
  assign bus.DATA_OUT   = r_data_out;
  assign bus.GRANT_ID   = r_grant_id;
  assign bus.BUSY       = (r_state == ST_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_rr_readout_arbiter.sv
// ============================================================================
// tb_rr_readout_arbiter : directed and random checks of rr_readout_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_readout_arbiter;

  logic clk;
  logic rst_n;

  rr_readout_arbiter_if #(.WIDTH(6), .DSIZE(32)) bus ();

  rr_readout_arbiter #(
    .WIDTH     (6),
    .DSIZE     (32),
    .MAX_BURST (4)
  ) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  en, hold;
  logic        ready;
  logic [31:0] q [6][$];
  int          pops [6];
  int          tests, fails;

  logic [5:0]  pre_req, pre_grant;
  logic        pre_wout, pre_busy, post_wout, post_busy;
  logic [31:0] pre_dout, post_dout;
  logic [2:0]  pre_gid, post_gid;
  logic        exp_wout;
  logic [31:0] exp_dout;

  // One bus cycle: drive from the source queues, sample before and after the edge
  task automatic cycle();
    logic [5:0]   req;
    logic [191:0] din;
    int           pop_ch;
    req = '0;
    din = '0;
    for (int i = 0; i < 6; i++) begin
      if (en[i] && q[i].size() > 0) begin
        req[i] = 1'b1;
        din[i*32 +: 32] = q[i][0];
      end
    end
    bus.WRITE_REQ = req;
    bus.DATA_IN   = din;
    bus.HOLD_REQ  = hold;
    bus.READY_IN  = ready;
    #1;
    pre_req   = req;
    pre_grant = bus.READ_GRANT;
    pre_wout  = bus.WRITE_OUT;
    pre_dout  = bus.DATA_OUT;
    pre_gid   = bus.GRANT_ID;
    pre_busy  = bus.BUSY;
    pop_ch = -1;
    for (int i = 5; i >= 0; i--) if (pre_grant[i]) pop_ch = i;
    if (pop_ch >= 0 && q[pop_ch].size() > 0) begin
      exp_dout = q[pop_ch].pop_front();
      exp_wout = 1'b1;
      pops[pop_ch]++;
    end else if (ready) begin
      exp_wout = 1'b0;
    end
    @(posedge clk);
    #1;
    post_wout = bus.WRITE_OUT;
    post_dout = bus.DATA_OUT;
    post_gid  = bus.GRANT_ID;
    post_busy = bus.BUSY;
    @(negedge clk);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 6; i++) begin
      q[i].delete();
      pops[i] = 0;
    end
  endtask

  task automatic fill(input int ch, input int n);
    for (int k = 0; k < n; k++) q[ch].push_back(32'hC000_0000 | (ch << 8) | k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests += 5;
    if (bus.READ_GRANT !== 6'h00) begin fails++; $display("FAIL rst_grant got=%h want=00", bus.READ_GRANT); end
    if (bus.WRITE_OUT !== 1'b0)   begin fails++; $display("FAIL rst_wout got=%b want=0", bus.WRITE_OUT); end
    if (bus.DATA_OUT !== 32'h0)   begin fails++; $display("FAIL rst_dout got=%h want=0", bus.DATA_OUT); end
    if (bus.GRANT_ID !== 3'd0)    begin fails++; $display("FAIL rst_gid got=%0d want=0", bus.GRANT_ID); end
    if (bus.BUSY !== 1'b0)        begin fails++; $display("FAIL rst_busy got=%b want=0", bus.BUSY); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) fill(i, 4);
    en = 6'h3F;
    repeat (3) cycle();
    tests++;
    if (post_wout !== 1'b1 || post_dout !== 32'hC000_0001) begin
      fails++; $display("FAIL rst_preburst wout=%b dout=%h want 1/c0000001", post_wout, post_dout);
    end
    rst_n = 1'b0;
    #1;
    tests += 5;
    if (bus.READ_GRANT !== 6'h00) begin fails++; $display("FAIL rst_mid_grant got=%h want=00", bus.READ_GRANT); end
    if (bus.WRITE_OUT !== 1'b0)   begin fails++; $display("FAIL rst_mid_wout got=%b want=0", bus.WRITE_OUT); end
    if (bus.DATA_OUT !== 32'h0)   begin fails++; $display("FAIL rst_mid_dout got=%h want=0", bus.DATA_OUT); end
    if (bus.GRANT_ID !== 3'd0)    begin fails++; $display("FAIL rst_mid_gid got=%0d want=0", bus.GRANT_ID); end
    if (bus.BUSY !== 1'b0)        begin fails++; $display("FAIL rst_mid_busy got=%b want=0", bus.BUSY); end
    @(posedge clk);
    #1;
    tests++;
    if (bus.READ_GRANT !== 6'h00 || bus.WRITE_OUT !== 1'b0) begin
      fails++; $display("FAIL rst_held grant=%h wout=%b want 00/0", bus.READ_GRANT, bus.WRITE_OUT);
    end
    @(negedge clk);
    en = 6'h00;
    clear_sources();
    exp_wout = 1'b0;
    exp_dout = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [5:0] want;
    clear_sources();
    for (int i = 0; i < 6; i++) fill(i, 8);
    en = 6'h3F; hold = 6'h00; ready = 1'b1;
    for (int k = 0; k < 35; k++) begin
      cycle();
      want = (k % 5 == 0) ? 6'h00 : 6'(1 << ((k / 5) % 6));
      tests += 2;
      if (pre_grant !== want) begin
        fails++; $display("FAIL rr_grant cyc=%0d got=%h want=%h", k, pre_grant, want);
      end
      if (post_wout !== exp_wout || (exp_wout && post_dout !== exp_dout)) begin
        fails++; $display("FAIL rr_data cyc=%0d got=%b/%h want=%b/%h", k, post_wout, post_dout, exp_wout, exp_dout);
      end
    end
    tests++;
    if (pops[0] != 8 || pops[5] != 4) begin
      fails++; $display("FAIL rr_counts ch0=%0d ch5=%0d want 8/4", pops[0], pops[5]);
    end
    en = 6'h00;
    clear_sources();
    repeat (2) cycle();
  endtask

  task automatic test_backpressure();
    clear_sources();
    fill(3, 3);
    fill(4, 3);
    en = 6'h3F;
    for (int k = 0; k < 30; k++) begin
      ready = (k % 2 == 0);
      cycle();
      tests += 2;
      if (post_wout !== exp_wout || (exp_wout && post_dout !== exp_dout)) begin
        fails++; $display("FAIL bp_data cyc=%0d got=%b/%h want=%b/%h", k, post_wout, post_dout, exp_wout, exp_dout);
      end
      if (pre_wout && !ready && (pre_grant !== 6'h00 || post_dout !== pre_dout)) begin
        fails++; $display("FAIL bp_stall cyc=%0d grant=%h dout=%h want 00/%h", k, pre_grant, post_dout, pre_dout);
      end
    end
    tests++;
    if (pops[3] != 3 || pops[4] != 3 || q[3].size() != 0 || q[4].size() != 0) begin
      fails++; $display("FAIL bp_counts ch3=%0d ch4=%0d want 3/3", pops[3], pops[4]);
    end
    ready = 1'b1;
    en = 6'h00;
    repeat (2) cycle();
  endtask

  task automatic test_hold();
    clear_sources();
    fill(0, 1);
    for (int i = 1; i < 6; i++) fill(i, 2);
    en = 6'h01; hold = 6'h01; ready = 1'b1;
    cycle();
    tests++;
    if (post_busy !== 1'b1 || post_gid !== 3'd0) begin
      fails++; $display("FAIL hold_start busy=%b gid=%0d want 1/0", post_busy, post_gid);
    end
    en = 6'h3F;
    for (int k = 1; k <= 40; k++) begin
      if (k % 5 == 0) q[0].push_back(32'hD000_0000 | k);
      cycle();
      tests += 2;
      if (pre_busy !== 1'b1 || pre_gid !== 3'd0 || (pre_grant & 6'h3E) !== 6'h00) begin
        fails++; $display("FAIL hold_keep cyc=%0d busy=%b gid=%0d grant=%h want 1/0/0x", k, pre_busy, pre_gid, pre_grant);
      end
      if (post_wout !== exp_wout || (exp_wout && post_dout !== exp_dout)) begin
        fails++; $display("FAIL hold_data cyc=%0d got=%b/%h want=%b/%h", k, post_wout, post_dout, exp_wout, exp_dout);
      end
    end
    tests++;
    if (pops[0] != 9) begin fails++; $display("FAIL hold_pops got=%0d want=9", pops[0]); end
    hold = 6'h00;
    cycle();
    tests++;
    if (pre_grant !== 6'h00 || post_busy !== 1'b0) begin
      fails++; $display("FAIL hold_release grant=%h busy=%b want 00/0", pre_grant, post_busy);
    end
    cycle();
    tests++;
    if (pre_grant !== 6'h00 || post_busy !== 1'b1 || post_gid !== 3'd1) begin
      fails++; $display("FAIL hold_next grant=%h busy=%b gid=%0d want 00/1/1", pre_grant, post_busy, post_gid);
    end
    cycle();
    tests++;
    if (pre_grant !== 6'h02) begin fails++; $display("FAIL hold_ch1pop got=%h want=02", pre_grant); end
    en = 6'h00;
    clear_sources();
    repeat (2) cycle();
  endtask

  task automatic test_empty_release();
    logic [5:0] want [10];
    want = '{6'h00, 6'h04, 6'h04, 6'h00, 6'h00, 6'h10, 6'h10, 6'h10, 6'h00, 6'h00};
    clear_sources();
    fill(2, 2);
    fill(4, 3);
    en = 6'h3F;
    for (int k = 0; k < 10; k++) begin
      cycle();
      tests++;
      if (pre_grant !== want[k]) begin
        fails++; $display("FAIL empty_grant cyc=%0d got=%h want=%h", k, pre_grant, want[k]);
      end
      if (k == 3 || k == 4) begin
        tests++;
        if (pre_busy !== (k == 3)) begin
          fails++; $display("FAIL empty_busy cyc=%0d got=%b want=%b", k, pre_busy, (k == 3));
        end
      end
    end
    // Request withdrawn in the very cycle the grant is registered
    fill(5, 1);
    en = 6'h20;
    cycle();
    tests++;
    if (post_busy !== 1'b1 || post_gid !== 3'd5) begin
      fails++; $display("FAIL drop_grant busy=%b gid=%0d want 1/5", post_busy, post_gid);
    end
    en = 6'h00;
    cycle();
    tests++;
    if (pre_grant !== 6'h00 || pre_busy !== 1'b1 || post_busy !== 1'b0) begin
      fails++; $display("FAIL drop_exit grant=%h busy=%b->%b want 00/1->0", pre_grant, pre_busy, post_busy);
    end
    clear_sources();
    cycle();
  endtask

  task automatic test_random();
    int seq;
    seq = 0;
    clear_sources();
    for (int k = 0; k < 10200; k++) begin
      for (int i = 0; i < 6; i++) begin
        if (k < 10000 && $urandom_range(0, 3) == 0 && q[i].size() < 8) begin
          q[i].push_back(32'hA000_0000 + seq);
          seq++;
        end
      end
      if (k < 10000) begin
        en    = 6'($urandom);
        ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 6; i++) hold[i] = ($urandom_range(0, 15) == 0);
      end else begin
        en = 6'h3F; ready = 1'b1; hold = 6'h00;
      end
      cycle();
      tests += 4;
      if ((pre_grant & (pre_grant - 6'd1)) !== 6'h00) begin
        fails++; $display("FAIL rnd_onehot cyc=%0d got=%h want onehot0", k, pre_grant);
      end
      if ((pre_grant & ~pre_req) !== 6'h00) begin
        fails++; $display("FAIL rnd_noreq cyc=%0d grant=%h req=%h", k, pre_grant, pre_req);
      end
      if (pre_wout && !ready && pre_grant !== 6'h00) begin
        fails++; $display("FAIL rnd_stall cyc=%0d grant=%h want=00", k, pre_grant);
      end
      if (post_wout !== exp_wout || (exp_wout && post_dout !== exp_dout)) begin
        fails++; $display("FAIL rnd_data cyc=%0d got=%b/%h want=%b/%h", k, post_wout, post_dout, exp_wout, exp_dout);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (q[i].size() != 0) begin
        fails++; $display("FAIL rnd_drain ch=%0d left=%0d want=0", i, q[i].size());
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    en = 6'h00; hold = 6'h00; ready = 1'b1;
    exp_wout = 1'b0; exp_dout = 32'h0;
    bus.WRITE_REQ = '0; bus.HOLD_REQ = '0; bus.DATA_IN = '0; bus.READY_IN = 1'b1;
    for (int i = 0; i < 6; i++) pops[i] = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_hold();
    test_empty_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
